writeback_queue: RTL and testbench
==================================

# writeback_queue

Dual-lane writeback buffer that accepts results from the two execution lanes and drives the two write ports of the 8-bit register file. Each lane has a small FIFO, so writes that momentarily cannot retire are held back rather than lost. The block also resolves same-destination conflicts in program order and drops writes to r0. It sits between the execute/memory stages and `registerFile`.

## Interface
Parameters:
- DEPTH, 4, entries per lane FIFO (power of two, ≥2)
- AW, 2, log2(DEPTH)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- flush  in  1  synchronous discard of all queued entries
- in_valid_1 / in_valid_2  in  1  lane result valid
- in_rd_1 / in_rd_2  in  5  destination register
- in_data_1 / in_data_2  in  8  result value
- in_ready_1 / in_ready_2  out  1  lane FIFO can accept (not full)
- rd_1 / rd_2  out  5  write-port destination
- writedata_1 / writedata_2  out  8  write-port data
- reg_write_1 / reg_write_2  out  1  write-port enable
- busy  out  1  any FIFO non-empty or any reg_write asserted
- wb_count  out  16  number of retired non-r0 writes, wraps

## Operation
- Push: lane k entry captured when in_valid_k && in_ready_k. in_ready_k = (count_k != DEPTH), computed from registered count only; a pop in the same cycle does not open space.
- Entries pushed on the same edge form a pair; lane 1 is the older member.
- Issue (combinational from heads, registered into outputs), evaluated each cycle:
  - Head with rd == 0 is popped and discarded; no reg_write; wb_count unchanged.
  - Both heads present, non-zero, different rd: both issued, both popped.
  - Both heads present, same non-zero rd: only lane 1 issued/popped this cycle; lane 2 issues the next cycle. The register file never sees rd_1 == rd_2 with both enables high.
  - Only one head present: that head is issued alone. Lane 2 is not held waiting for lane 1.
- wb_count increments by the number of reg_write bits set in the registered outputs (0, 1 or 2), modulo 2^16.
- flush: both FIFOs emptied and reg_write_1/2 cleared on the next edge. Any push in the flush cycle is dropped. wb_count is kept.
- Reset has priority over flush and push.

## Timing
- Reset (reset == 0 at edge): pointers/counts = 0; in_ready_1/2 = 1 after the edge; reg_write_1/2 = 0; rd_1/2 = 0; writedata_1/2 = 0; busy = 0; wb_count = 0.
- Latency: an entry accepted at edge t into an empty lane is issued at edge t+1. reg_write is high for the one cycle following edge t+1.
- Throughput: one write per lane per cycle when there are no conflicts.
- When no write is issued, rd/writedata hold their last values and reg_write is 0.
- Full lane: in_ready_k = 0 for the whole cycle; in_valid_k must be held by the producer.
- Pointers wrap modulo DEPTH. count_k = DEPTH denotes full; pointer equality alone is not used.
- Simultaneous push+pop on a non-full lane: count is unchanged and both operations take effect.
- Reset asserted mid-stream: queued entries are lost, and outputs are at reset values after that edge.

## Test plan
- Reset, then push lane1 (rd=3, 0x5A) at edge 1 -> reg_write_1=1, rd_1=3, writedata_1=0x5A for exactly one cycle after edge 2; wb_count=1.
- Same-cycle pair lane1 (rd=7, 0x11) + lane2 (rd=7, 0x22) -> cycle A: only reg_write_1 (7, 0x11); cycle A+1: only reg_write_2 (7, 0x22); wb_count +2.
- Push rd=0 on lane2 alongside lane1 (rd=4, 0x33) -> only reg_write_1 asserted; wb_count +1.
- Hold in_valid_1 with 5 entries and DEPTH=4, with lane-1 writes consumed each cycle -> in_ready_1 behaviour matches count; all 5 values retire in order, none lost or duplicated.
- Fill both lanes, assert flush -> next cycle busy=0, reg_write_1/2=0, in_ready_1/2=1; wb_count unchanged.
- Preload wb_count to 0xFFFF via 65535 writes, then issue a pair -> wb_count = 0x0001.

Source files
------------

// File: rtl/writeback_queue_if.sv
// Lane-result and register-file write-port bundle for writeback_queue.
// The producer side holds master; the queue itself holds slave.
interface writeback_queue_if;
    logic        flush;
    logic        in_valid_1;
    logic        in_valid_2;
    logic [4:0]  in_rd_1;
    logic [4:0]  in_rd_2;
    logic [7:0]  in_data_1;
    logic [7:0]  in_data_2;
    logic        in_ready_1;
    logic        in_ready_2;
    logic [4:0]  rd_1;
    logic [4:0]  rd_2;
    logic [7:0]  writedata_1;
    logic [7:0]  writedata_2;
    logic        reg_write_1;
    logic        reg_write_2;
    logic        busy;
    logic [15:0] wb_count;

    modport master (
        output flush, in_valid_1, in_valid_2, in_rd_1, in_rd_2, in_data_1, in_data_2,
        input  in_ready_1, in_ready_2, rd_1, rd_2, writedata_1, writedata_2,
               reg_write_1, reg_write_2, busy, wb_count
    );

    modport slave (
        input  flush, in_valid_1, in_valid_2, in_rd_1, in_rd_2, in_data_1, in_data_2,
        output in_ready_1, in_ready_2, rd_1, rd_2, writedata_1, writedata_2,
               reg_write_1, reg_write_2, busy, wb_count
    );
endinterface

// File: rtl/writeback_queue.sv
// Dual-lane writeback buffer: per-lane FIFOs feeding the two register-file write
// ports, with r0 drop and same-destination ordering (lane 1 first).
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    writeback_queue_if.slave  bus
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    mem_rd   [2][DEPTH];
    logic [7:0]    mem_data [2][DEPTH];
    logic [AW-1:0] wr_ptr   [2];
    logic [AW-1:0] rd_ptr   [2];
    logic [AW:0]   count    [2];

    logic [4:0]    in_rd     [2];
    logic [7:0]    in_data   [2];
    logic [4:0]    head_rd   [2];
    logic [7:0]    head_data [2];
    logic [1:0]    in_valid, in_ready, head_valid, push, pop, issue;
    logic          conflict;

    logic [4:0]    out_rd   [2];
    logic [7:0]    out_data [2];
    logic [1:0]    out_we;
    logic [15:0]   wb_cnt;

    assign in_valid   = {bus.in_valid_2, bus.in_valid_1};
    assign in_rd[0]   = bus.in_rd_1;
    assign in_rd[1]   = bus.in_rd_2;
    assign in_data[0] = bus.in_data_1;
    assign in_data[1] = bus.in_data_2;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            head_valid[k] = (count[k] != '0);
            head_rd[k]    = mem_rd[k][rd_ptr[k]];
            head_data[k]  = mem_data[k][rd_ptr[k]];
            in_ready[k]   = (count[k] != FULL);
            push[k]       = in_valid[k] && in_ready[k] && !bus.flush;
        end
        // Same non-zero destination on both heads: lane 1 is older, lane 2 waits a cycle.
        conflict = (&head_valid) && (head_rd[0] != '0) && (head_rd[0] == head_rd[1]);
        pop      = {head_valid[1] && !conflict, head_valid[0]};
        for (int k = 0; k < 2; k++) begin
            issue[k] = pop[k] && (head_rd[k] != '0);
        end
    end

    // NOTE: storage has no reset; only pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem_rd[k][wr_ptr[k]]   <= in_rd[k];
                mem_data[k][wr_ptr[k]] <= in_data[k];
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every lane sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k]   <= '0;
                rd_ptr[k]   <= '0;
                count[k]    <= '0;
                out_rd[k]   <= '0;
                out_data[k] <= '0;
            end
            out_we <= '0;
            wb_cnt <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
            out_we <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
                count[k] <= count[k] + (AW+1)'(push[k]) - (AW+1)'(pop[k]);
                if (issue[k]) begin
                    out_rd[k]   <= head_rd[k];
                    out_data[k] <= head_data[k];
                end
            end
            out_we <= issue;
            wb_cnt <= wb_cnt + {15'd0, issue[0]} + {15'd0, issue[1]};
        end
    end

    assign bus.in_ready_1  = in_ready[0];
    assign bus.in_ready_2  = in_ready[1];
    assign bus.rd_1        = out_rd[0];
    assign bus.rd_2        = out_rd[1];
    assign bus.writedata_1 = out_data[0];
    assign bus.writedata_2 = out_data[1];
    assign bus.reg_write_1 = out_we[0];
    assign bus.reg_write_2 = out_we[1];
    assign bus.busy        = (|head_valid) || (|out_we);
    assign bus.wb_count    = wb_cnt;
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0] rd;
        logic [7:0] data;
    } entry_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    writeback_queue_if bus ();

    writeback_queue #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    entry_t      q1[$], q2[$];
    entry_t      pend1[$], pend2[$];
    logic        m_rw1, m_rw2;
    logic [4:0]  m_rd1, m_rd2;
    logic [7:0]  m_wd1, m_wd2;
    logic [15:0] m_wb;
    bit          m_acc1, m_acc2;
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predict from the model, advance the edge, then compare every output.
    task automatic step();
        entry_t e1, e2, n1, n2;
        bit hv1, hv2, conflict, p1, p2, i1, i2, a1, a2;
        e1 = '{rd: 5'd0, data: 8'd0};
        e2 = '{rd: 5'd0, data: 8'd0};
        check("in_ready_1", bus.in_ready_1, q1.size() < DEPTH);
        check("in_ready_2", bus.in_ready_2, q2.size() < DEPTH);
        hv1 = q1.size() != 0;
        hv2 = q2.size() != 0;
        if (hv1) e1 = q1[0];
        if (hv2) e2 = q2[0];
        n1 = '{rd: bus.in_rd_1, data: bus.in_data_1};
        n2 = '{rd: bus.in_rd_2, data: bus.in_data_2};
        a1 = bus.in_valid_1 && (q1.size() < DEPTH) && !bus.flush && reset;
        a2 = bus.in_valid_2 && (q2.size() < DEPTH) && !bus.flush && reset;
        m_acc1 = a1;
        m_acc2 = a2;
        conflict = hv1 && hv2 && (e1.rd != 0) && (e1.rd == e2.rd);
        p1 = hv1;
        p2 = hv2 && !conflict;
        i1 = p1 && (e1.rd != 0);
        i2 = p2 && (e2.rd != 0);
        @(posedge clk);
        #1;
        if (!reset) begin
            q1.delete(); q2.delete();
            m_rw1 = 0; m_rw2 = 0; m_rd1 = 0; m_rd2 = 0; m_wd1 = 0; m_wd2 = 0; m_wb = 0;
        end else if (bus.flush) begin
            q1.delete(); q2.delete();
            m_rw1 = 0; m_rw2 = 0;
        end else begin
            if (p1) void'(q1.pop_front());
            if (p2) void'(q2.pop_front());
            if (a1) q1.push_back(n1);
            if (a2) q2.push_back(n2);
            m_rw1 = i1;
            m_rw2 = i2;
            if (i1) begin m_rd1 = e1.rd; m_wd1 = e1.data; end
            if (i2) begin m_rd2 = e2.rd; m_wd2 = e2.data; end
            m_wb = m_wb + 16'(i1) + 16'(i2);
        end
        check("reg_write_1", bus.reg_write_1, m_rw1);
        check("reg_write_2", bus.reg_write_2, m_rw2);
        check("rd_1", bus.rd_1, m_rd1);
        check("rd_2", bus.rd_2, m_rd2);
        check("writedata_1", bus.writedata_1, m_wd1);
        check("writedata_2", bus.writedata_2, m_wd2);
        check("wb_count", bus.wb_count, m_wb);
        check("busy", bus.busy, (q1.size() != 0) || (q2.size() != 0) || m_rw1 || m_rw2);
    endtask

    task automatic idle(input int n);
        bus.in_valid_1 = 0;
        bus.in_valid_2 = 0;
        repeat (n) step();
    endtask

    // Producer model: presents pending heads and holds them until accepted.
    task automatic run_pending(input int budget, input bit must_finish);
        int c = 0;
        while ((pend1.size() != 0 || pend2.size() != 0) && c < budget) begin
            bus.in_valid_1 = pend1.size() != 0;
            bus.in_valid_2 = pend2.size() != 0;
            if (pend1.size() != 0) begin bus.in_rd_1 = pend1[0].rd; bus.in_data_1 = pend1[0].data; end
            if (pend2.size() != 0) begin bus.in_rd_2 = pend2[0].rd; bus.in_data_2 = pend2[0].data; end
            step();
            if (m_acc1) void'(pend1.pop_front());
            if (m_acc2) void'(pend2.pop_front());
            c++;
        end
        if (must_finish) check("pending_drained", pend1.size() + pend2.size(), 0);
        bus.in_valid_1 = 0;
        bus.in_valid_2 = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_miss);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] wb_before;
        bus.flush = 0;
        bus.in_valid_1 = 0; bus.in_valid_2 = 0;
        bus.in_rd_1 = 0; bus.in_rd_2 = 0;
        bus.in_data_1 = 0; bus.in_data_2 = 0;
        m_acc1 = 0; m_acc2 = 0;
        m_rw1 = 0; m_rw2 = 0; m_rd1 = 0; m_rd2 = 0; m_wd1 = 0; m_wd2 = 0; m_wb = 0;

        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_write_1", bus.reg_write_1, 0);
        check("rst_reg_write_2", bus.reg_write_2, 0);
        check("rst_rd_1", bus.rd_1, 0);
        check("rst_writedata_2", bus.writedata_2, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_wb_count", bus.wb_count, 0);
        check("rst_in_ready_1", bus.in_ready_1, 1);
        check("rst_in_ready_2", bus.in_ready_2, 1);
        reset = 1;

        // Single lane-1 write: issued one edge after acceptance, visible for one cycle.
        bus.in_valid_1 = 1; bus.in_rd_1 = 5'd3; bus.in_data_1 = 8'h5A;
        step();
        bus.in_valid_1 = 0;
        step();
        check("t1_reg_write_1", bus.reg_write_1, 1);
        check("t1_rd_1", bus.rd_1, 3);
        check("t1_writedata_1", bus.writedata_1, 8'h5A);
        check("t1_wb_count", bus.wb_count, 1);
        step();
        check("t1_reg_write_1_off", bus.reg_write_1, 0);

        // Same-destination pair: lane 1 first, lane 2 the following cycle.
        bus.in_valid_1 = 1; bus.in_rd_1 = 5'd7; bus.in_data_1 = 8'h11;
        bus.in_valid_2 = 1; bus.in_rd_2 = 5'd7; bus.in_data_2 = 8'h22;
        step();
        idle(1);
        check("t2a_reg_write_1", bus.reg_write_1, 1);
        check("t2a_reg_write_2", bus.reg_write_2, 0);
        check("t2a_writedata_1", bus.writedata_1, 8'h11);
        idle(1);
        check("t2b_reg_write_1", bus.reg_write_1, 0);
        check("t2b_reg_write_2", bus.reg_write_2, 1);
        check("t2b_rd_2", bus.rd_2, 7);
        check("t2b_writedata_2", bus.writedata_2, 8'h22);
        check("t2b_wb_count", bus.wb_count, 3);
        idle(1);

        // r0 on lane 2 is discarded.
        bus.in_valid_1 = 1; bus.in_rd_1 = 5'd4; bus.in_data_1 = 8'h33;
        bus.in_valid_2 = 1; bus.in_rd_2 = 5'd0; bus.in_data_2 = 8'h99;
        step();
        idle(1);
        check("t3_reg_write_1", bus.reg_write_1, 1);
        check("t3_reg_write_2", bus.reg_write_2, 0);
        check("t3_rd_1", bus.rd_1, 4);
        idle(2);
        check("t3_wb_count", bus.wb_count, 4);

        // Five back-to-back lane-1 entries, retired in order.
        for (int i = 1; i <= 5; i++) pend1.push_back('{rd: 5'(i), data: 8'(8'hA0 + i)});
        run_pending(20, 1);
        idle(3);
        check("t4_wb_count", bus.wb_count, 9);

        // Lane 2 backs up behind a stream of same-destination lane-1 writes until full.
        for (int i = 0; i < 6; i++) begin
            pend1.push_back('{rd: 5'd9, data: 8'(i)});
            pend2.push_back('{rd: 5'd9, data: 8'(8'h40 + i)});
        end
        run_pending(40, 1);
        idle(8);
        check("t4b_wb_count", bus.wb_count, 21);

        // Flush with both lanes loaded and a push attempted in the flush cycle.
        for (int i = 0; i < 6; i++) begin
            pend1.push_back('{rd: 5'd9, data: 8'(8'h60 + i)});
            pend2.push_back('{rd: 5'd9, data: 8'(8'h70 + i)});
        end
        run_pending(5, 0);
        bus.in_valid_1 = 1; bus.in_valid_2 = 1;
        bus.flush = 1;
        wb_before = m_wb;
        step();
        bus.flush = 0;
        bus.in_valid_1 = 0; bus.in_valid_2 = 0;
        pend1.delete(); pend2.delete();
        check("t5_busy", bus.busy, 0);
        check("t5_reg_write_1", bus.reg_write_1, 0);
        check("t5_reg_write_2", bus.reg_write_2, 0);
        check("t5_in_ready_1", bus.in_ready_1, 1);
        check("t5_in_ready_2", bus.in_ready_2, 1);
        check("t5_wb_count", bus.wb_count, wb_before);
        idle(3);

        // wb_count wrap: 65535 retired writes, then one more pair.
        reset = 0;
        step();
        reset = 1;
        bus.in_valid_1 = 1; bus.in_rd_1 = 5'd1; bus.in_data_1 = 8'h01;
        step();
        bus.in_valid_2 = 1; bus.in_rd_2 = 5'd2; bus.in_data_2 = 8'h02;
        repeat (32767) step();
        idle(4);
        check("t6_wb_full", bus.wb_count, 16'hFFFF);
        bus.in_valid_1 = 1; bus.in_rd_1 = 5'd5; bus.in_data_1 = 8'h55;
        bus.in_valid_2 = 1; bus.in_rd_2 = 5'd6; bus.in_data_2 = 8'h66;
        step();
        idle(3);
        check("t6_wb_wrap", bus.wb_count, 16'h0001);

        // Random traffic with held requests, occasional flush and reset.
        m_acc1 = 0; m_acc2 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!(bus.in_valid_1 && !m_acc1)) begin
                bus.in_valid_1 = $urandom_range(0, 3) != 0;
                bus.in_rd_1    = 5'($urandom_range(0, 3));
                bus.in_data_1  = 8'($urandom);
            end
            if (!(bus.in_valid_2 && !m_acc2)) begin
                bus.in_valid_2 = $urandom_range(0, 3) != 0;
                bus.in_rd_2    = 5'($urandom_range(0, 3));
                bus.in_data_2  = 8'($urandom);
            end
            bus.flush = $urandom_range(0, 59) == 0;
            reset     = $urandom_range(0, 199) != 0;
            step();
        end
        bus.flush = 0;
        reset = 1;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
